img_loader: RTL
===============

IMG_LOADER -- requirements
Module: img_loader

Interface
REQ-001 Parameter LOAD_BYTES, default 65536, number of input image bytes written to data memory (1..65536).
REQ-002 Parameter OUT_BASE, default 16'h0000, first data-memory address of the downsampled result.
REQ-003 Parameter OUT_BYTES, default 16384, number of result bytes streamed out (1..65536).
REQ-004 Ports: clk in 1 clock; rst_n in 1 async active-low reset; start in 1 begin a job pulse; s_valid in 1 input byte valid; s_data in 8 input byte; s_ready out 1 input byte accepted.
REQ-005 Ports: mem_addr out 16 data-memory address; mem_wdata out 8 write byte; mem_we out 1 write strobe; mem_re out 1 read strobe; mem_rdata in 8 read byte, valid one cycle after mem_re.
REQ-006 Ports: mem_sel out 1, 1 = processor owns data memory; proc_enable out 1 processor enable; proc_finish in 1 processor finish flag.
REQ-007 Ports: m_valid out 1 result byte valid; m_data out 8 result byte; m_ready in 1 downstream accepts; done out 1 job complete; chk_sum out 8 input checksum.

Function
REQ-008 FSM states IDLE, LOAD, RUN, DUMP, DONE; one state per cycle, encoded in a shared enum.
REQ-009 IDLE->LOAD on start=1; start is ignored in every other state.
REQ-010 LOAD: s_ready=1; each s_valid&&s_ready cycle drives mem_we=1, mem_addr=load count, mem_wdata=s_data in the same cycle, then increments the load count.
REQ-011 LOAD->RUN in the cycle after the LOAD_BYTES-th byte is accepted; s_ready=0 from that cycle on.
REQ-012 RUN: mem_sel=1, proc_enable=1, mem_we=0, mem_re=0; RUN->DUMP on the first cycle proc_finish=1; proc_finish outside RUN is ignored.
REQ-013 DUMP: mem_sel=0, proc_enable=0; reads addresses OUT_BASE..OUT_BASE+OUT_BYTES-1 in order; 16-bit address wraps modulo 65536.
REQ-014 DUMP output path is a 2-entry FIFO; mem_re issues only when occupancy plus in-flight reads is below 2; sustains 1 byte/cycle with m_ready held 1.
REQ-015 m_valid=1 whenever the FIFO is non-empty; m_data is stable while m_valid=1 and m_ready=0.
REQ-016 DUMP->DONE in the cycle after the OUT_BYTES-th byte handshakes; DONE asserts done=1 for exactly one cycle, then returns to IDLE.
REQ-017 mem_we and mem_re are never both 1; both are 0 outside LOAD/DUMP.

Reset
REQ-018 rst_n=0 asynchronously forces IDLE, clears counters and FIFO, and drives s_ready, mem_we, mem_re, mem_sel, proc_enable, m_valid, done to 0 and mem_addr, mem_wdata, m_data, chk_sum to 0.
REQ-019 Reset mid-job abandons the job; no partial byte is emitted after release.

Configuration
REQ-020 Macro IMG_LOADER_CHECKSUM_EN defined: chk_sum is the modulo-256 sum of all bytes accepted in LOAD, cleared on start, held from RUN until next start.
REQ-021 Macro undefined: no checksum logic; chk_sum tied to 0.

Structure
REQ-022 Shared package holds the FSM state enum, address width (16), and data width (8).
REQ-023 The 2-entry output FIFO is a separate sub-module, out_fifo2.

Verification
REQ-024 LOAD_BYTES=4: start, bytes 11,22,33,44 with s_valid gapped -> writes at addresses 0..3, s_ready=0 after 4th, state RUN, proc_enable=1.
REQ-025 In RUN, proc_finish=1 for one cycle -> next cycle mem_sel=0, proc_enable=0, first mem_re to OUT_BASE.
REQ-026 OUT_BASE=16'hFFFF, OUT_BYTES=2, m_ready=1 -> reads FFFF then 0000, two m_valid handshakes, done pulse 1 cycle.
REQ-027 OUT_BYTES=3, m_ready toggling 0/1 every cycle -> no byte lost or duplicated, m_data stable while stalled, mem_re never with FIFO full.
REQ-028 rst_n asserted mid-DUMP -> all outputs 0 immediately; new start reloads from address 0.
REQ-029 With IMG_LOADER_CHECKSUM_EN, bytes FF,02 -> chk_sum=01; without macro chk_sum=00.

Source files
------------

// File: rtl/img_loader_pkg.sv
// ---------------------------------------------------------------------------
// img_loader_pkg
//   Definitions shared by the image loader and its output FIFO:
//   - ADDR_W / DATA_W : data-memory address and byte widths
//   - state_t         : job sequencer states
//   - count_last()    : index of the final item of an n-item run
// ---------------------------------------------------------------------------
package img_loader_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    DUMP,
    DONE
  } state_t;

  // Index of the last item in a run of n items (n in 1..2**ADDR_W).
  function automatic logic [ADDR_W-1:0] count_last(input int unsigned n);
    return ADDR_W'(n - 1);
  endfunction

endpackage

// File: rtl/img_loader_out_fifo2.sv
// ---------------------------------------------------------------------------
// out_fifo2
//   Two-entry FIFO that decouples data-memory read returns from the
//   downstream valid/ready handshake during the dump phase.
//
//   clk, rst_n  : clock, asynchronous active-low reset
//   flush       : synchronous clear of pointers and occupancy
//   push        : write push_data (ignored when full)
//   push_data   : byte to store
//   pop         : remove the head entry (ignored when empty)
//   head        : current head entry
//   count       : occupancy, 0..2
//   empty, full : occupancy flags
// ---------------------------------------------------------------------------
module out_fifo2
  import img_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [1:0]        count,
  output logic              empty,
  output logic              full
);

  logic [DATA_W-1:0] slot [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == 2'd0);
  assign full    = (count == 2'd2);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = slot[rd_ptr];

  // NOTE: the storage is reset along with the pointers; with only two
  // entries this is cheap and guarantees the head reads 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) slot[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        slot[wr_ptr] <= push_data;
        wr_ptr       <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/img_loader.sv
// ---------------------------------------------------------------------------
// img_loader
//   Job sequencer for an image-processing accelerator:
//     LOAD : streams LOAD_BYTES input bytes into data memory at 0..N-1
//     RUN  : hands data memory to the processor until proc_finish
//     DUMP : reads OUT_BYTES result bytes from OUT_BASE (wrapping at 64K)
//            and streams them out through a 2-entry FIFO
//     DONE : one-cycle done pulse, then back to IDLE
//
//   Parameters: LOAD_BYTES (1..65536), OUT_BASE, OUT_BYTES (1..65536)
//
//   Ports:
//     clk, rst_n                 clock, asynchronous active-low reset
//     start                      begin a job (honoured in IDLE only)
//     s_valid, s_data, s_ready   input byte stream
//     mem_addr, mem_wdata,
//     mem_we, mem_re, mem_rdata  data-memory port (read data one cycle
//                                after mem_re)
//     mem_sel                    1 = processor owns data memory
//     proc_enable, proc_finish   processor control / completion
//     m_valid, m_data, m_ready   result byte stream
//     done                       job-complete pulse
//     chk_sum                    input checksum
//
//   Build option: define IMG_LOADER_CHECKSUM_EN to make chk_sum the
//   modulo-256 sum of the bytes accepted in LOAD; otherwise chk_sum is 0.
// ---------------------------------------------------------------------------
module img_loader
  import img_loader_pkg::*;
#(
  parameter int unsigned       LOAD_BYTES = 65536,
  parameter logic [ADDR_W-1:0] OUT_BASE   = 16'h0000,
  parameter int unsigned       OUT_BYTES  = 16384
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_sel,
  output logic              proc_enable,
  input  logic              proc_finish,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_ready,
  output logic              done,
  output logic [DATA_W-1:0] chk_sum
);

  localparam logic [ADDR_W-1:0] LOAD_LAST = count_last(LOAD_BYTES);
  localparam logic [ADDR_W-1:0] OUT_LAST  = count_last(OUT_BYTES);
  localparam logic [ADDR_W:0]   OUT_TOTAL = (ADDR_W + 1)'(OUT_BYTES);

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] load_cnt;     // next write address in LOAD
  logic [ADDR_W:0]   rd_cnt;       // reads issued in DUMP (reaches OUT_BYTES)
  logic [ADDR_W-1:0] out_cnt;      // result bytes handshaken in DUMP
  logic              rd_inflight;  // a read was issued last cycle
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_pending;
  logic              slot_free;
  logic              job_start;
  logic              load_fire;
  logic              rd_fire;
  logic              out_fire;

  logic [1:0]        fifo_count;
  logic              fifo_empty;
  logic              fifo_full;
  logic [2:0]        occ_after;

  assign job_start  = (state == IDLE) && start;
  assign rd_addr    = OUT_BASE + rd_cnt[ADDR_W-1:0];  // wraps modulo 64K
  assign rd_pending = (rd_cnt < OUT_TOTAL);
  assign m_valid    = !fifo_empty;
  assign out_fire   = m_valid && m_ready;

  // A slot is reserved for every read still in flight. The byte leaving
  // this cycle frees its slot immediately, which is what lets a read issue
  // every cycle while m_ready stays high; a full FIFO never takes a read.
  assign occ_after = 3'(fifo_count) + 3'(rd_inflight) - 3'(out_fire);
  assign slot_free = !fifo_full && (occ_after < 3'd2);

  // NOTE: every output and strobe gets a default before the case so that
  // no path through this block can infer a latch.
  always_comb begin
    state_nx    = state;
    s_ready     = 1'b0;
    mem_we      = 1'b0;
    mem_re      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_sel     = 1'b0;
    proc_enable = 1'b0;
    done        = 1'b0;
    load_fire   = 1'b0;
    rd_fire     = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) state_nx = LOAD;
      end
      LOAD: begin
        s_ready   = 1'b1;
        load_fire = s_valid;
        if (load_fire) begin
          mem_we    = 1'b1;
          mem_addr  = load_cnt;
          mem_wdata = s_data;
          if (load_cnt == LOAD_LAST) state_nx = RUN;
        end
      end
      RUN: begin
        mem_sel     = 1'b1;
        proc_enable = 1'b1;
        if (proc_finish) state_nx = DUMP;
      end
      DUMP: begin
        rd_fire = rd_pending && slot_free;
        mem_re  = rd_fire;
        if (rd_fire) mem_addr = rd_addr;
        if (out_fire && (out_cnt == OUT_LAST)) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values of the cycle that just ended.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      load_cnt    <= '0;
      rd_cnt      <= '0;
      out_cnt     <= '0;
      rd_inflight <= 1'b0;
    end else begin
      state       <= state_nx;
      rd_inflight <= rd_fire;

      if (job_start)      load_cnt <= '0;
      else if (load_fire) load_cnt <= load_cnt + 1'b1;

      // Dump counters are armed while the processor runs.
      if (state == RUN) begin
        rd_cnt  <= '0;
        out_cnt <= '0;
      end else begin
        if (rd_fire)  rd_cnt  <= rd_cnt + 1'b1;
        if (out_fire) out_cnt <= out_cnt + 1'b1;
      end
    end
  end

  // Read data returns one cycle after mem_re; rd_inflight marks that cycle.
  out_fifo2 u_out_fifo2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (state == IDLE),
    .push      (rd_inflight),
    .push_data (mem_rdata),
    .pop       (out_fire),
    .head      (m_data),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

`ifdef IMG_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         sum_q <= '0;
    else if (job_start) sum_q <= '0;
    else if (load_fire) sum_q <= sum_q + s_data;
  end

  assign chk_sum = sum_q;
`else
  assign chk_sum = '0;
`endif

endmodule
